ma_lsu: RTL and testbench
=========================

# ma_lsu

Memory-access stage load/store unit for the RV32I pipeline; sits between the EX stage and the byte-laned 1R1W data RAM. Turns one EX-stage load/store request per cycle into RAM word address, byte-lane write enables and lane-aligned write data. One cycle later it extracts, aligns and sign/zero-extends the RAM read word into a write-back value. It also holds load results across MA/WB stalls and flags misaligned or illegal accesses.

## Interface
- DRWIDTH, 9, RAM word-address width (RAM holds 2**DRWIDTH 32-bit words)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents a memory request this cycle
- ex_load  in  1  request is a load (exclusive with ex_store)
- ex_store  in  1  request is a store
- ex_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr  in  32  byte address
- ex_wdata  in  32  store data (rs2), bits right-justified
- ex_rd  in  5  load destination register
- stall  in  1  downstream hold; no request accepted, WB outputs frozen
- ram_radr  out  DRWIDTH  RAM read word address (RAM registers it)
- ram_wadr  out  DRWIDTH  RAM write word address
- ram_wdata  out  32  lane-replicated store data
- ram_wen  out  4  byte-lane write enables
- ram_rdata  in  32  RAM read word, valid the cycle after ram_radr sampled
- wb_valid  out  1  load result present
- wb_rd  out  5  destination register
- wb_ldata  out  32  extended load data
- ma_err  out  1  one-cycle pulse: misaligned or illegal access
- ma_err_addr  out  32  faulting byte address, held until next error

## Operation
- Accept: acc = ex_valid & (ex_load | ex_store) & ~stall.
- ram_radr = ram_wadr = ex_addr[DRWIDTH+1:2], combinational; upper address bits ignored (wrap).
- Alignment check: H/HU need addr[0]=0; W needs addr[1:0]=00. Store funct3 not in {000,001,010} and load funct3 in {011,110,111} are illegal. Either condition sets bad.
- Stores (acc & ~bad): B lanes 1<<addr[1:0], wdata = {4{wdata[7:0]}}; H lanes 0011 or 1100 by addr[1], wdata = {2{wdata[15:0]}}; W lanes 1111, wdata unchanged. Otherwise ram_wen = 0000.
- Loads: on acc & ex_load & ~bad, register rd, funct3, addr[1:0]; wb_valid=1 next cycle.
- Extraction: byte selected by addr[1:0], half by addr[1]; B/H sign-extend, BU/HU zero-extend, W pass-through.
- Stall hold: wb_valid, wb_rd, pending funct3/offset keep their values while stall=1. On the first stall cycle with wb_valid=1, the extracted value is captured in hold_reg and hold_vld is set. While hold_vld=1, wb_ldata = hold_reg; otherwise wb_ldata is the combinational extraction. hold_vld clears on the first cycle with stall=0 after that.
- No stall, no load accepted: wb_valid clears next cycle.
- Error: acc & bad registers ma_err=1 and ma_err_addr=ex_addr next cycle; no RAM write, wb_valid=0 for it.

## Timing
- Reset values: wb_valid 0, wb_rd 0, ma_err 0, ma_err_addr 0, hold_vld 0, hold_reg 0. wb_ldata follows from these.
- RAM outputs are combinational from EX inputs; ram_wen is forced 0 when stall=1 or rst_n=0.
- Store accepted cycle N: RAM written at the end of N.
- Load accepted cycle N: wb_valid/wb_rd in N+1, wb_ldata valid in N+1. Latency 1, throughput 1/cycle.
- Store N then load N+1, same word: load returns new data (write precedes registered read).
- Load N then store N+1, same word: load returns old data. Extraction in N+1 precedes the write edge.
- Reset asserted mid-stall: hold and WB state cleared immediately.
- ma_err is exactly one cycle unless errors occur back to back.

## Test plan
- SW 0x11223344 @0x10, then LW @0x10 -> ram_wen 1111 in cycle N; next cycle wb_valid=1, wb_ldata=0x11223344.
- SB 0xA5 @0x13, then LB/LBU @0x13 -> wen 1000, wdata 0xA5A5A5A5; LB 0xFFFFFFA5, LBU 0x000000A5.
- SH 0x8001 @0x22, then LH/LHU @0x22 -> wen 1100; LH 0xFFFF8001, LHU 0x00008001.
- LW @0x10, stall 3 cycles while a store to 0x10 writes the RAM via an external path -> wb_ldata holds the original value for all stall cycles.
- LW @0x12, SH @0x21 -> ram_wen 0000, ma_err pulses, ma_err_addr 0x12 then 0x21, wb_valid 0.
- rst_n low during pending load -> wb_valid 0 asynchronously; first request after release behaves normally.

Source files
------------

// File: rtl/ma_lsu.sv
// Memory-access stage load/store unit: maps EX requests onto a byte-laned RAM
// and aligns/extends the registered read word into a write-back value.
module ma_lsu #(
    parameter int DRWIDTH = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic               ex_load,
    input  logic               ex_store,
    input  logic [2:0]         ex_funct3,
    input  logic [31:0]        ex_addr,
    input  logic [31:0]        ex_wdata,
    input  logic [4:0]         ex_rd,
    input  logic               stall,
    output logic [DRWIDTH-1:0] ram_radr,
    output logic [DRWIDTH-1:0] ram_wadr,
    output logic [31:0]        ram_wdata,
    output logic [3:0]         ram_wen,
    input  logic [31:0]        ram_rdata,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_ldata,
    output logic               ma_err,
    output logic [31:0]        ma_err_addr
);

    logic        acc;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        illegal;
    logic        bad;
    logic        ld_acc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        hold_vld_q, hold_vld_d;
    logic [31:0] hold_reg_q, hold_reg_d;
    logic        ma_err_q, ma_err_d;
    logic [31:0] ma_err_addr_q, ma_err_addr_d;

    // Address bits above the RAM word index are ignored, so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ex_addr[31:DRWIDTH+2];

    assign acc        = ex_valid & (ex_load | ex_store) & ~stall;
    assign is_half    = (ex_funct3[1:0] == 2'b01);
    assign is_word    = (ex_funct3[1:0] == 2'b10);
    assign misaligned = (is_half & ex_addr[0]) | (is_word & (ex_addr[1:0] != 2'b00));
    assign illegal    = ex_store ? (ex_funct3[2] | (ex_funct3[1:0] == 2'b11))
                                 : ((ex_funct3[1:0] == 2'b11) | (ex_funct3 == 3'b110));
    assign bad        = misaligned | illegal;
    assign ld_acc     = acc & ex_load & ~bad;

    assign ram_radr = ex_addr[DRWIDTH+1:2];
    assign ram_wadr = ex_addr[DRWIDTH+1:2];

    always_comb begin
        ram_wen   = 4'b0000;
        ram_wdata = ex_wdata;
        case (ex_funct3[1:0])
            2'b00:   ram_wdata = {4{ex_wdata[7:0]}};
            2'b01:   ram_wdata = {2{ex_wdata[15:0]}};
            default: ram_wdata = ex_wdata;
        endcase
        if (acc & ex_store & ~bad & rst_n) begin
            case (ex_funct3[1:0])
                2'b00:   ram_wen = 4'b0001 << ex_addr[1:0];
                2'b01:   ram_wen = ex_addr[1] ? 4'b1100 : 4'b0011;
                2'b10:   ram_wen = 4'b1111;
                default: ram_wen = 4'b0000;
            endcase
        end
    end

    always_comb begin
        ld_byte = ram_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = ram_rdata;
        endcase
    end

    // The RAM keeps re-reading while stalled, so the first stalled result is frozen in hold_reg.
    always_comb begin
        wb_valid_d    = wb_valid_q;
        wb_rd_d       = wb_rd_q;
        f3_d          = f3_q;
        off_d         = off_q;
        hold_vld_d    = hold_vld_q;
        hold_reg_d    = hold_reg_q;
        ma_err_d      = acc & bad;
        ma_err_addr_d = ma_err_addr_q;
        if (!stall) begin
            wb_valid_d = ld_acc;
            if (ld_acc) begin
                wb_rd_d = ex_rd;
                f3_d    = ex_funct3;
                off_d   = ex_addr[1:0];
            end
        end
        if (stall & wb_valid_q & ~hold_vld_q) begin
            hold_vld_d = 1'b1;
            hold_reg_d = ld_ext;
        end else if (!stall) begin
            hold_vld_d = 1'b0;
        end
        if (acc & bad) begin
            ma_err_addr_d = ex_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'd0;
            f3_q          <= 3'd0;
            off_q         <= 2'd0;
            hold_vld_q    <= 1'b0;
            hold_reg_q    <= 32'd0;
            ma_err_q      <= 1'b0;
            ma_err_addr_q <= 32'd0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            f3_q          <= f3_d;
            off_q         <= off_d;
            hold_vld_q    <= hold_vld_d;
            hold_reg_q    <= hold_reg_d;
            ma_err_q      <= ma_err_d;
            ma_err_addr_q <= ma_err_addr_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_ldata    = hold_vld_q ? hold_reg_q : ld_ext;
    assign ma_err      = ma_err_q;
    assign ma_err_addr = ma_err_addr_q;

endmodule

// File: tb/tb_ma_lsu.sv
// Directed bench for ma_lsu with a behavioural byte-laned RAM that registers its read address.
module tb_ma_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_load, ex_store, stall;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic [8:0]  ram_radr, ram_wadr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_wen;
    logic        wb_valid, ma_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_ldata, ma_err_addr;

    logic        extWe;
    logic [8:0]  extWord;
    logic [31:0] extData;
    logic [31:0] mem [0:511];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ma_lsu #(.DRWIDTH(9)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .stall(stall),
        .ram_radr(ram_radr), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
        .ram_rdata(ram_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_ldata(wb_ldata),
        .ma_err(ma_err), .ma_err_addr(ma_err_addr)
    );

    // Lane writes and the registered read share an edge, so a same-edge read sees the old word.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_wadr][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (extWe) mem[extWord] <= extData;
        ram_rdata <= mem[ram_radr];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
    endtask

    task automatic req(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
        ex_valid = 1'b1; ex_load = ld; ex_store = ~ld;
        ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    endtask

    task automatic test_reset();
        req(1'b0, 3'b010, 32'h10, 32'hFFFFFFFF, 5'd0);
        #1;
        checks++; if (ram_wen !== 4'b0000) begin fails++; $display("[TB] FAIL rst_wen: got %b expected %b", ram_wen, 4'b0000); end
        checks++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (wb_rd !== 5'd0) begin fails++; $display("[TB] FAIL rst_wb_rd: got %h expected 00", wb_rd); end
        checks++; if (ma_err !== 1'b0) begin fails++; $display("[TB] FAIL rst_ma_err: got %b expected 0", ma_err); end
        checks++; if (ma_err_addr !== 32'd0) begin fails++; $display("[TB] FAIL rst_ma_err_addr: got %h expected 00000000", ma_err_addr); end
        step();
        step();
        idle();
        rst_n = 1'b1;
        step();
        checks++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL post_rst_wb_valid: got %b expected 0", wb_valid); end
    endtask

    task automatic test_word();
        req(1'b0, 3'b010, 32'h10, 32'h11223344, 5'd0);
        #1;
        checks++; if (ram_wen !== 4'b1111) begin fails++; $display("[TB] FAIL sw_wen: got %b expected 1111", ram_wen); end
        checks++; if (ram_wdata !== 32'h11223344) begin fails++; $display("[TB] FAIL sw_wdata: got %h expected 11223344", ram_wdata); end
        checks++; if (ram_wadr !== 9'h004) begin fails++; $display("[TB] FAIL sw_wadr: got %h expected 004", ram_wadr); end
        step();
        req(1'b1, 3'b010, 32'h10, 32'd0, 5'd5);
        step();
        req(1'b1, 3'b010, 32'hFFFFF810, 32'd0, 5'd0);
        #1;
        checks++; if (ram_radr !== 9'h004) begin fails++; $display("[TB] FAIL wrap_radr: got %h expected 004", ram_radr); end
        idle();
        checks++; if (wb_valid !== 1'b1) begin fails++; $display("[TB] FAIL lw_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_rd !== 5'd5) begin fails++; $display("[TB] FAIL lw_rd: got %0d expected 5", wb_rd); end
        checks++; if (wb_ldata !== 32'h11223344) begin fails++; $display("[TB] FAIL lw_data: got %h expected 11223344", wb_ldata); end
        step();
        checks++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL lw_valid_clear: got %b expected 0", wb_valid); end
    endtask

    task automatic test_byte();
        req(1'b0, 3'b000, 32'h13, 32'h123456A5, 5'd0);
        #1;
        checks++; if (ram_wen !== 4'b1000) begin fails++; $display("[TB] FAIL sb_wen: got %b expected 1000", ram_wen); end
        checks++; if (ram_wdata !== 32'hA5A5A5A5) begin fails++; $display("[TB] FAIL sb_wdata: got %h expected A5A5A5A5", ram_wdata); end
        step();
        req(1'b1, 3'b000, 32'h13, 32'd0, 5'd6);
        step();
        req(1'b1, 3'b100, 32'h13, 32'd0, 5'd7);
        checks++; if (wb_rd !== 5'd6) begin fails++; $display("[TB] FAIL lb_rd: got %0d expected 6", wb_rd); end
        checks++; if (wb_ldata !== 32'hFFFFFFA5) begin fails++; $display("[TB] FAIL lb_data: got %h expected FFFFFFA5", wb_ldata); end
        step();
        req(1'b1, 3'b010, 32'h10, 32'd0, 5'd8);
        checks++; if (wb_rd !== 5'd7) begin fails++; $display("[TB] FAIL lbu_rd: got %0d expected 7", wb_rd); end
        checks++; if (wb_ldata !== 32'h000000A5) begin fails++; $display("[TB] FAIL lbu_data: got %h expected 000000A5", wb_ldata); end
        step();
        idle();
        checks++; if (wb_ldata !== 32'hA5223344) begin fails++; $display("[TB] FAIL sb_lanes: got %h expected A5223344", wb_ldata); end
        step();
    endtask

    task automatic test_half();
        req(1'b0, 3'b001, 32'h22, 32'hDEAD8001, 5'd0);
        #1;
        checks++; if (ram_wen !== 4'b1100) begin fails++; $display("[TB] FAIL sh_hi_wen: got %b expected 1100", ram_wen); end
        checks++; if (ram_wdata !== 32'h80018001) begin fails++; $display("[TB] FAIL sh_wdata: got %h expected 80018001", ram_wdata); end
        step();
        req(1'b0, 3'b001, 32'h20, 32'h00007FFF, 5'd0);
        #1;
        checks++; if (ram_wen !== 4'b0011) begin fails++; $display("[TB] FAIL sh_lo_wen: got %b expected 0011", ram_wen); end
        step();
        req(1'b1, 3'b001, 32'h22, 32'd0, 5'd9);
        step();
        req(1'b1, 3'b101, 32'h22, 32'd0, 5'd10);
        checks++; if (wb_ldata !== 32'hFFFF8001) begin fails++; $display("[TB] FAIL lh_data: got %h expected FFFF8001", wb_ldata); end
        step();
        req(1'b1, 3'b001, 32'h20, 32'd0, 5'd11);
        checks++; if (wb_ldata !== 32'h00008001) begin fails++; $display("[TB] FAIL lhu_data: got %h expected 00008001", wb_ldata); end
        step();
        idle();
        checks++; if (wb_ldata !== 32'h00007FFF) begin fails++; $display("[TB] FAIL lh_pos_data: got %h expected 00007FFF", wb_ldata); end
        step();
    endtask

    task automatic test_stall();
        req(1'b0, 3'b010, 32'h10, 32'hCAFEF00D, 5'd0);
        step();
        req(1'b1, 3'b010, 32'h10, 32'd0, 5'd12);
        step();
        stall = 1'b1;
        req(1'b0, 3'b010, 32'h10, 32'h0BADBEEF, 5'd0);
        extWe = 1'b1; extWord = 9'd4; extData = 32'h0BADBEEF;
        #1;
        checks++; if (ram_wen !== 4'b0000) begin fails++; $display("[TB] FAIL stall_wen: got %b expected 0000", ram_wen); end
        checks++; if (wb_ldata !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL stall1_data: got %h expected CAFEF00D", wb_ldata); end
        step();
        extWe = 1'b0;
        for (int i = 2; i <= 3; i++) begin
            checks++; if (wb_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall%0d_valid: got %b expected 1", i, wb_valid); end
            checks++; if (wb_rd !== 5'd12) begin fails++; $display("[TB] FAIL stall%0d_rd: got %0d expected 12", i, wb_rd); end
            checks++; if (wb_ldata !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL stall%0d_data: got %h expected CAFEF00D", i, wb_ldata); end
            step();
        end
        stall = 1'b0;
        idle();
        #1;
        checks++; if (wb_valid !== 1'b1) begin fails++; $display("[TB] FAIL release_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_ldata !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL release_data: got %h expected CAFEF00D", wb_ldata); end
        step();
        checks++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL release_clear: got %b expected 0", wb_valid); end
        req(1'b1, 3'b010, 32'h10, 32'd0, 5'd13);
        step();
        idle();
        checks++; if (wb_ldata !== 32'h0BADBEEF) begin fails++; $display("[TB] FAIL ext_write_data: got %h expected 0BADBEEF", wb_ldata); end
        step();
    endtask

    task automatic test_errors();
        req(1'b1, 3'b010, 32'h12, 32'd0, 5'd3);
        #1;
        checks++; if (ram_wen !== 4'b0000) begin fails++; $display("[TB] FAIL lw_mis_wen: got %b expected 0000", ram_wen); end
        step();
        req(1'b0, 3'b001, 32'h21, 32'h00001234, 5'd0);
        #1;
        checks++; if (ram_wen !== 4'b0000) begin fails++; $display("[TB] FAIL sh_mis_wen: got %b expected 0000", ram_wen); end
        checks++; if (ma_err !== 1'b1) begin fails++; $display("[TB] FAIL err1_pulse: got %b expected 1", ma_err); end
        checks++; if (ma_err_addr !== 32'h12) begin fails++; $display("[TB] FAIL err1_addr: got %h expected 00000012", ma_err_addr); end
        checks++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL err1_wb_valid: got %b expected 0", wb_valid); end
        step();
        idle();
        checks++; if (ma_err !== 1'b1) begin fails++; $display("[TB] FAIL err2_pulse: got %b expected 1", ma_err); end
        checks++; if (ma_err_addr !== 32'h21) begin fails++; $display("[TB] FAIL err2_addr: got %h expected 00000021", ma_err_addr); end
        step();
        checks++; if (ma_err !== 1'b0) begin fails++; $display("[TB] FAIL err_clear: got %b expected 0", ma_err); end
        checks++; if (ma_err_addr !== 32'h21) begin fails++; $display("[TB] FAIL err_addr_hold: got %h expected 00000021", ma_err_addr); end
        req(1'b0, 3'b100, 32'h10, 32'hFFFFFFFF, 5'd0);
        #1;
        checks++; if (ram_wen !== 4'b0000) begin fails++; $display("[TB] FAIL ill_store_wen: got %b expected 0000", ram_wen); end
        step();
        req(1'b1, 3'b011, 32'h14, 32'd0, 5'd4);
        checks++; if (ma_err_addr !== 32'h10) begin fails++; $display("[TB] FAIL ill_store_addr: got %h expected 00000010", ma_err_addr); end
        step();
        idle();
        checks++; if (ma_err_addr !== 32'h14) begin fails++; $display("[TB] FAIL ill_load_addr: got %h expected 00000014", ma_err_addr); end
        checks++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL ill_load_valid: got %b expected 0", wb_valid); end
        req(1'b1, 3'b010, 32'h10, 32'd0, 5'd14);
        step();
        idle();
        checks++; if (wb_ldata !== 32'h0BADBEEF) begin fails++; $display("[TB] FAIL ill_store_nowrite: got %h expected 0BADBEEF", wb_ldata); end
        step();
    endtask

    task automatic test_reset_mid();
        req(1'b0, 3'b010, 32'h30, 32'h5555AAAA, 5'd0);
        step();
        req(1'b1, 3'b010, 32'h30, 32'd0, 5'd15);
        step();
        stall = 1'b1;
        idle();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL async_rst_valid: got %b expected 0", wb_valid); end
        checks++; if (wb_rd !== 5'd0) begin fails++; $display("[TB] FAIL async_rst_rd: got %0d expected 0", wb_rd); end
        stall = 1'b0;
        req(1'b0, 3'b010, 32'h10, 32'hFFFFFFFF, 5'd0);
        #1;
        checks++; if (ram_wen !== 4'b0000) begin fails++; $display("[TB] FAIL rst_store_wen: got %b expected 0000", ram_wen); end
        step();
        rst_n = 1'b1;
        req(1'b1, 3'b010, 32'h10, 32'd0, 5'd16);
        step();
        idle();
        checks++; if (wb_valid !== 1'b1) begin fails++; $display("[TB] FAIL post_rst_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_rd !== 5'd16) begin fails++; $display("[TB] FAIL post_rst_rd: got %0d expected 16", wb_rd); end
        checks++; if (wb_ldata !== 32'h0BADBEEF) begin fails++; $display("[TB] FAIL post_rst_data: got %h expected 0BADBEEF", wb_ldata); end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        extWe = 1'b0; extWord = 9'd0; extData = 32'd0;
        idle();
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_stall();
        test_errors();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
